alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ALU_LAT, 1: cycles from alu_en pulse to valid alu_y/alu_carry/alu_zero; legal range 1..4.
- DW, 8: operand width.
- OPW, 4: opcode width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic is rising-edge.
- rst_n, in, 1: asynchronous, active-low reset.
- reqN_valid, in, 1: requester N (N=0,1) has an operation.
- reqN_ready, out, 1: requester N operation accepted this cycle.
- reqN_a, in, DW: operand a.
- reqN_b, in, DW: operand b.
- reqN_op, in, OPW: ALU select code.
- alu_a, out, DW: operand a to the shared ALU.
- alu_b, out, DW: operand b to the shared ALU.
- alu_s, out, OPW: select code to the shared ALU.
- alu_en, out, 1: one-cycle ALU enable pulse.
- alu_y, in, 2*DW: ALU result.
- alu_carry, in, 1: ALU carry flag.
- alu_zero, in, 1: ALU zero flag.
- rsp_valid, out, 1: response available.
- rsp_ready, in, 1: consumer accepts the response.
- rsp_id, out, 1: requester index that owns the response.
- rsp_y, out, 2*DW: captured result.
- rsp_carry, out, 1: captured carry flag.
- rsp_zero, out, 1: captured zero flag.
- busy, out, 1: high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-004 In IDLE, reqN_ready SHALL be high only for the grant winner, combinationally from the valid inputs; both ready signals SHALL be low in all other states.
REQ-005 A transfer SHALL occur when reqN_valid and reqN_ready are both high; operands, opcode and id are latched, and the FSM moves to ISSUE.
REQ-006 If both requesters are valid, the winner SHALL be the requester not granted last; if only one is valid, that requester wins.
REQ-007 The last-grant pointer SHALL update only on an accepted transfer.
REQ-008 In ISSUE, alu_en SHALL be high for exactly one cycle, followed by WAIT.
REQ-009 alu_a, alu_b and alu_s SHALL hold the latched values from ISSUE through the end of WAIT, and SHALL be zero in IDLE and RESP.
REQ-010 WAIT SHALL last ALU_LAT cycles, counted by a down-counter loaded with ALU_LAT-1.
REQ-011 On the final WAIT cycle, alu_y/alu_carry/alu_zero SHALL be registered into rsp_y/rsp_carry/rsp_zero, and the FSM moves to RESP.
REQ-012 Latency from the accept edge to rsp_valid high SHALL be 2+ALU_LAT cycles.
REQ-013 In RESP, rsp_valid SHALL stay high and rsp_y, rsp_carry, rsp_zero and rsp_id SHALL stay stable until rsp_ready is high.
REQ-014 rsp_ready high in the first RESP cycle SHALL complete the handshake in that cycle; the FSM is in IDLE the next cycle.
REQ-015 New requests SHALL NOT be accepted in the RESP-exit cycle; the earliest next accept is the following IDLE cycle.
REQ-016 reqN_valid changes outside IDLE SHALL have no effect.
REQ-017 rsp_ready while rsp_valid is low SHALL be ignored.

Reset
REQ-018 Asserting rst_n low SHALL immediately force the following, including mid-operation, which aborts the in-flight operation with no response:
- state IDLE;
- all outputs 0;
- WAIT counter 0;
- last-grant pointer = 1, so requester 0 wins the first tie.
REQ-019 Release of rst_n SHALL be synchronous to clk.

Configuration
REQ-020 With macro ALU_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win ties and the pointer SHALL be unused.
REQ-021 With ALU_ARB_FIXED_PRIO_EN undefined, arbitration SHALL be round-robin as in REQ-006/REQ-007.

Structure
REQ-022 Package alu_ctrl_pkg SHALL hold the FSM state enum, DW and OPW defaults, and the ALU_LAT maximum constant (4).
REQ-023 Grant selection, including the fixed/round-robin choice, SHALL be in sub-module alu_rr_arbiter (2 requests in, one-hot grant out, pointer update input).

Verification (bench ALU model: op 4'b0001 = add, registered, ALU_LAT=1)
REQ-024 Single request:
- Stimulus: req0 a=8'hEE, b=8'hEE, op=4'b0001.
- Response: accepted in IDLE; alu_en pulse one cycle later; rsp_valid 3 cycles after accept; rsp_y=16'h01DC, rsp_carry=1, rsp_id=0.
REQ-025 Contention:
- Stimulus: both requesters valid continuously, rsp_ready tied high.
- Response: grants alternate 0,1,0,1; one accept every 4 cycles.
REQ-026 Backpressure:
- Stimulus: rsp_ready held low for 10 cycles.
- Response: rsp_valid and rsp_y stable throughout; no reqN_ready asserted; completes on the cycle rsp_ready rises.
REQ-027 Reset mid-operation:
- Stimulus: rst_n low during WAIT.
- Response: next sample shows all outputs 0 and busy=0; after release, a simultaneous req0/req1 pair grants req0 first.
REQ-028 Fixed priority:
- Stimulus: ALU_ARB_FIXED_PRIO_EN defined; both requesters always valid.
- Response: req1 is never granted over 8 operations.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and defaults for the two-requester ALU arbiter.
// The ALU_ARB_FIXED_PRIO_EN macro is consumed by alu_rr_arbiter.
package alu_ctrl_pkg;

  localparam int DW_DEF      = 8;
  localparam int OPW_DEF     = 4;
  localparam int ALU_LAT_MAX = 4;
  localparam int CNT_W       = $clog2(ALU_LAT_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way grant selection. Round-robin on ties by default; with
// ALU_ARB_FIXED_PRIO_EN defined requester 0 always wins and no pointer exists.
module alu_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, upd};
  assign gnt[0]    = req[0];
  assign gnt[1]    = req[1] & ~req[0];
`else
  // last = index granted most recently; reset to 1 so requester 0 wins the first tie
  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last <= 1'b1;
    else if (upd) last <= gnt[1];
  end

  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU between two requesters: accept, issue, wait, respond.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) over round-robin.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int DW      = DW_DEF,
  parameter int OPW     = OPW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic [OPW-1:0]  req0_op,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic [OPW-1:0]  req1_op,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [OPW-1:0]  alu_s,
  output logic            alu_en,
  input  logic [2*DW-1:0] alu_y,
  input  logic            alu_carry,
  input  logic            alu_zero,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [2*DW-1:0] rsp_y,
  output logic            rsp_carry,
  output logic            rsp_zero,
  output logic            busy
);

  alu_state_e       state, nxt;
  logic [1:0]       gnt;
  logic             accept;
  logic [DW-1:0]    a_q, b_q;
  logic [OPW-1:0]   s_q;
  logic             id_q;
  logic [CNT_W-1:0] cnt;
  logic             wait_done;

  alu_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1_valid, req0_valid}),
    .upd   (accept),
    .gnt   (gnt)
  );

  // rst_n gate keeps ready low while reset is held even if valids are high
  assign req0_ready = (state == IDLE) & gnt[0] & rst_n;
  assign req1_ready = (state == IDLE) & gnt[1] & rst_n;
  assign accept     = req0_ready | req1_ready;
  assign wait_done  = (state == WAIT) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    alu_en    = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_s     = '0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) nxt = ISSUE;
      end
      ISSUE: begin
        alu_en = 1'b1;
        alu_a  = a_q;
        alu_b  = b_q;
        alu_s  = s_q;
        nxt    = WAIT;
      end
      WAIT: begin
        alu_a = a_q;
        alu_b = b_q;
        alu_s = s_q;
        if (cnt == '0) nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      id_q      <= 1'b0;
      cnt       <= '0;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= gnt[1] ? req1_a  : req0_a;
        b_q  <= gnt[1] ? req1_b  : req0_b;
        s_q  <= gnt[1] ? req1_op : req0_op;
        id_q <= gnt[1];
      end
      // loaded during ISSUE so WAIT spans exactly ALU_LAT cycles
      if (state == ISSUE)                    cnt <= CNT_W'(ALU_LAT - 1);
      else if (state == WAIT && cnt != '0)   cnt <= cnt - 1'b1;
      if (wait_done) begin
        rsp_y     <= alu_y;
        rsp_carry <= alu_carry;
        rsp_zero  <= alu_zero;
        rsp_id    <= id_q;
      end
    end
  end

endmodule
